axi_rd_sram: RTL and testbench
==============================

# axi_rd_sram

AXI4 read-only responder backed by a word-addressed synchronous SRAM. It answers the instruction-fetch refill bursts issued by the fetch path's ICache and serves as the instruction memory model in simulation and FPGA builds. It supports FIXED, INCR and WRAP bursts and sustains one beat per cycle under continuous `rready`. A backdoor write port preloads program images.

## Interface
- `DATA_W`, default 32: data bus width; only 32 is supported.
- `ID_W`, default 4: transaction ID width.
- `DEPTH`, default 4096: SRAM depth in 32-bit words; must be a power of two.
- `BASE`, default 32'h80000000: byte address of word 0.
- `LAT`, default 1: cycles from AR handshake to first `rvalid`; minimum 1.
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `arvalid` in 1: address valid.
- `arready` out 1: address accepted.
- `araddr` in 32: start byte address.
- `arid` in ID_W: transaction ID.
- `arlen` in 8: beats minus one.
- `arsize` in 3: log2 bytes per beat.
- `arburst` in 2: 0=FIXED, 1=INCR, 2=WRAP.
- `rvalid` out 1: beat valid.
- `rready` in 1: beat accepted.
- `rdata` out 32: beat data.
- `rresp` out 2: 0=OKAY, 2=SLVERR, 3=DECERR.
- `rid` out ID_W: echoes `arid`.
- `rlast` out 1: final beat.
- `init_we` in 1: backdoor write enable.
- `init_addr` in log2(DEPTH): backdoor word index.
- `init_data` in 32: backdoor write data.

## Operation
- State machine: IDLE → WAIT → BURST → IDLE.
- IDLE: `arready`=1. An AR handshake latches addr/id/len/size/burst, loads the latency counter to LAT-1, and moves to WAIT. If LAT=1, it moves directly to BURST.
- WAIT: `arready`=0. The counter decrements each cycle; at 0 the state becomes BURST.
- BURST: `arready`=0, `rvalid`=1. The beat counter advances on `rvalid & rready`. The handshake on the beat with `rlast`=1 (beat index == len) returns to IDLE.
- Error classification is per burst, decided at AR accept:
  - `arsize` != 2 → SLVERR on every beat.
  - `arburst`=3 → SLVERR on every beat.
  - WRAP with len not in {1,3,7,15} → SLVERR on every beat.
  - WRAP with `araddr` not 4-aligned → SLVERR on every beat.
- SLVERR bursts still return len+1 beats with `rdata`=0 and correct `rlast`.
- Address advance after each accepted beat:
  - FIXED: unchanged.
  - INCR: +4 (the low two bits of the first address are ignored).
  - WRAP: +4 within an aligned window of (len+1)*4 bytes; the address wraps to the window base.
- Decode, per beat: an address outside [BASE, BASE+4*DEPTH) gives DECERR with `rdata`=0. An INCR burst running off the array end gives DECERR from that beat onward; earlier beats are OKAY.
- SRAM is synchronous-read. The read index each cycle is the next beat's index if the current beat fires, otherwise the current index. `rdata` therefore holds stable while `rvalid & ~rready`.
- All of `rdata`/`rresp`/`rid`/`rlast` are stable while `rvalid & ~rready`.
- Backdoor write happens on any cycle. On the same word, an SRAM read in that cycle returns old data (read-first).

## Timing
- Reset values: `arready`=1, `rvalid`=0, `rlast`=0, `rresp`=0, `rid`=0, `rdata`=0, state IDLE.
- AR handshake at cycle T → first `rvalid` at T+LAT.
- With `rready` held high, beats follow back-to-back: last beat at T+LAT+len.
- Last-beat handshake at cycle U → `arready`=1 at U+1. No AR overlap, one outstanding transaction.
- `rvalid` never depends combinationally on `rready`. `arready` is registered.
- Reset mid-burst aborts the transaction: `rvalid`=0 the next cycle, no `rlast` is issued, and SRAM contents are preserved.
- `arlen`=255 (256 beats): the beat counter is 8 bits and compares to len without overflow.

## Structure
- Shared package `axi_pkg`:
  - `axi_burst_e` (FIXED/INCR/WRAP)
  - `axi_resp_e` (OKAY/EXOKAY/SLVERR/DECERR)
  - constant `AXI_SIZE_W32`=2
- Sub-module `axi_burst_addr`: combinational next-address calculator from addr/len/burst, with a WRAP mask. Reused later by a write responder.
- SRAM array is inferred inline.

## Test plan
- Preload words 0..7 = 0x100..0x107. INCR, araddr=0x80000000, len=3, LAT=1, rready=1 → data 0x100..0x103 at T+1..T+4, rlast at T+4, arready=1 at T+5.
- WRAP, araddr=0x80000008, len=3 → data 0x102, 0x103, 0x100, 0x101, all OKAY.
- INCR, araddr=BASE+4*DEPTH-8, len=3 → beats 0-1 OKAY with array data, beats 2-3 DECERR with rdata=0, rlast on beat 3.
- rready toggles 1,0,0,1,… during len=7 INCR with LAT=3 → first rvalid at T+3; data/rlast stable through stalls; 8 beats in order; arid=5 echoed on every beat.
- arsize=1, len=1 → two SLVERR beats, rdata=0. Then assert reset during beat 2 of a len=7 burst → rvalid=0 next cycle, arready=1, a new read returns correct preloaded data.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI4 encodings (burst types, responses, beat size) and
//            small helpers used by the SRAM-backed AXI responders.
// Revision : 1.0  initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  // Only 4-byte beats are served by the 32-bit responders.
  localparam logic [2:0] AXI_SIZE_W32 = 3'd2;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr
// Brief    : Combinational next-beat address for FIXED/INCR/WRAP bursts of
//            4-byte beats. The WRAP window is (len+1)*4 bytes, aligned.
// Revision : 1.0  initial release
// ============================================================================
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  // INCR ignores the low address bits of the first beat.
  assign incr_addr = {addr_i[31:2], 2'b00} + 32'd4;

  // For legal wrap lengths (1,3,7,15) the window size minus one is {len,2'b11}.
  assign wrap_mask = {22'd0, len_i, 2'b11};

  // Select the advance rule for the latched burst type.
  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_sram.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_sram
// Brief    : AXI4 read-only responder over a word-addressed synchronous SRAM,
//            one outstanding burst, one beat per cycle, backdoor preload port.
// Revision : 1.0  initial release
// ============================================================================
module axi_rd_sram
  import axi_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          ID_W   = 4,
  parameter int          DEPTH  = 4096,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          LAT    = 1
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [31:0]              araddr,
  input  logic [ID_W-1:0]          arid,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic [ID_W-1:0]          rid,
  output logic                     rlast,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [DATA_W-1:0]        init_data
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        beat_q, beat_d;
  logic [31:0]       addr_q, addr_d;
  logic              arready_q;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic              slverr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic              ar_fire;
  logic              r_fire;
  logic              ar_err;
  logic [31:0]       next_addr;
  logic [31:0]       rd_addr;
  logic [31:0]       rd_off;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       beat_off;
  logic              in_range;
  axi_resp_e         resp;

  assign ar_fire = arvalid & arready_q;
  assign r_fire  = (state_q == ST_BURST) & rready;

  // Whole-burst error classification, made once when AR is accepted.
  assign ar_err = (arsize != AXI_SIZE_W32) ||
                  (arburst == 2'd3) ||
                  ((arburst == BURST_WRAP) && (!wrap_len_ok(arlen) || (araddr[1:0] != 2'b00)));

  axi_burst_addr u_burst_addr (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Next state, latency countdown, beat counter and beat address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_fire) begin
          addr_d  = araddr;
          beat_d  = 8'd0;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = (LAT == 1) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (r_fire) begin
          beat_d = beat_q + 8'd1;
          addr_d = next_addr;
          if (beat_q == len_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; arready is registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      beat_q    <= 8'd0;
      addr_q    <= 32'd0;
      arready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      arready_q <= (state_d == ST_IDLE);
    end
  end

  // Burst attributes held for the life of the transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_q     <= '0;
      len_q    <= 8'd0;
      burst_q  <= 2'd0;
      slverr_q <= 1'b0;
    end else if (ar_fire) begin
      id_q     <= arid;
      len_q    <= arlen;
      burst_q  <= arburst;
      slverr_q <= ar_err;
    end
  end

  // Read the word the next presented beat needs: a new burst's first
  // address, the following beat on a handshake, otherwise hold.
  assign rd_addr = ar_fire ? araddr : (r_fire ? next_addr : addr_q);
  assign rd_off  = rd_addr - BASE;
  assign rd_idx  = IDX_W'(rd_off >> 2);

  // Synchronous-read SRAM with read-first behaviour on backdoor collisions.
  always_ff @(posedge clock) begin
    if (init_we) mem_q[init_addr] <= init_data;
    rd_data_q <= mem_q[rd_idx];
  end

  // Per-beat decode; addresses below BASE wrap to large offsets.
  assign beat_off = addr_q - BASE;
  assign in_range = (beat_off < SPAN);

  // Beat response: burst-level SLVERR wins over per-beat DECERR.
  always_comb begin
    resp = RESP_OKAY;
    if (state_q == ST_BURST) begin
      if (slverr_q)       resp = RESP_SLVERR;
      else if (!in_range) resp = RESP_DECERR;
    end
  end

  assign arready = arready_q;
  assign rvalid  = (state_q == ST_BURST);
  assign rresp   = resp;
  assign rdata   = (rvalid && (resp == RESP_OKAY)) ? rd_data_q : '0;
  assign rid     = id_q;
  assign rlast   = rvalid && (beat_q == len_q);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_sram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_sram
// Brief    : Scoreboard bench for axi_rd_sram; a LAT=1 and a LAT=3 instance
//            share the AR/R stimulus, selected by sel.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_sram;
  import axi_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr  = '0;
  logic [3:0]  arid    = '0;
  logic [7:0]  arlen   = '0;
  logic [2:0]  arsize  = 3'd2;
  logic [1:0]  arburst = 2'd1;
  logic        rready  = 1'b0;
  logic        init_we = 1'b0;
  logic [11:0] init_addr = '0;
  logic [31:0] init_data = '0;

  logic        arvalid_a, arvalid_b;
  logic        arready_a, arready_b, rvalid_a, rvalid_b, rlast_a, rlast_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  rresp_a, rresp_b;
  logic [3:0]  rid_a, rid_b;
  logic        arready_m, rvalid_m, rlast_m;
  logic [31:0] rdata_m;
  logic [1:0]  rresp_m;
  logic [3:0]  rid_m;

  logic [31:0] model_mem [DEPTH];
  beat_t       sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  assign arvalid_a = arvalid & ~sel;
  assign arvalid_b = arvalid & sel;
  assign arready_m = sel ? arready_b : arready_a;
  assign rvalid_m  = sel ? rvalid_b  : rvalid_a;
  assign rlast_m   = sel ? rlast_b   : rlast_a;
  assign rdata_m   = sel ? rdata_b   : rdata_a;
  assign rresp_m   = sel ? rresp_b   : rresp_a;
  assign rid_m     = sel ? rid_b     : rid_a;

  axi_rd_sram #(.DATA_W(32), .ID_W(4), .DEPTH(DEPTH), .BASE(BASE), .LAT(1)) u_dut_lat1 (
    .clock(clock), .reset(reset),
    .arvalid(arvalid_a), .arready(arready_a), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a), .rresp(rresp_a),
    .rid(rid_a), .rlast(rlast_a),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  axi_rd_sram #(.DATA_W(32), .ID_W(4), .DEPTH(DEPTH), .BASE(BASE), .LAT(3)) u_dut_lat3 (
    .clock(clock), .reset(reset),
    .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b), .rresp(rresp_b),
    .rid(rid_b), .rlast(rlast_b),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference beat i of a burst, computed from the AXI rules directly.
  function automatic beat_t model_beat(input logic [31:0] addr0, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst, input int i);
    beat_t       b;
    logic [31:0] a, bytes, wbase;
    logic        err;
    err = (size != 3'd2) || (burst == 2'd3) ||
          ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
          ((burst == 2'd2) && (addr0[1:0] != 2'b00));
    a = addr0;
    if (burst == 2'd1) a = {addr0[31:2], 2'b00} + 32'(4 * i);
    if (burst == 2'd2 && !err) begin
      bytes = (32'(len) + 32'd1) * 32'd4;
      wbase = addr0 - (addr0 % bytes);
      a     = wbase + ((addr0 - wbase + 32'(4 * i)) % bytes);
    end
    b.last = (i == int'(len));
    if (err) begin
      b.resp = 2'd2; b.data = 32'd0;
    end else if (a < BASE || a >= BASE + 32'(4 * DEPTH)) begin
      b.resp = 2'd3; b.data = 32'd0;
    end else begin
      b.resp = 2'd0; b.data = model_mem[int'((a - BASE) >> 2)];
    end
    return b;
  endfunction

  // Issue one burst and score every presented beat; called and returns on a negedge.
  task automatic do_read(input string tag, input logic s, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input int pat, input int lat);
    int    n, k;
    logic  done, first;
    beat_t e;
    for (int i = 0; i <= int'(len); i++) sb_q.push_back(model_beat(addr, len, size, burst, i));
    sel = s; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1; rready = 1'b0;
    check_eq({tag, "_arready_idle"}, 32'(arready_m), 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
    n = 1; k = 0; done = 1'b0; first = 1'b1;
    while (!done && n < 2000) begin
      if (rvalid_m) begin
        if (first) begin
          check_eq({tag, "_first_rvalid_cycle"}, 32'(n), 32'(lat));
          first = 1'b0;
        end
        rready = (pat == 0) || (k % 3 == 0);
        k++;
        e = sb_q[0];
        check_eq({tag, "_rdata"}, rdata_m, e.data);
        check_eq({tag, "_rresp"}, 32'(rresp_m), 32'(e.resp));
        check_eq({tag, "_rlast"}, 32'(rlast_m), 32'(e.last));
        check_eq({tag, "_rid"}, 32'(rid_m), 32'(id));
        if (rready) begin
          void'(sb_q.pop_front());
          if (e.last) done = 1'b1;
        end
      end
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_completed"}, 32'(done), 32'd1);
    rready = 1'b0;
    check_eq({tag, "_arready_after"}, 32'(arready_m), 32'd1);
    check_eq({tag, "_rvalid_after"}, 32'(rvalid_m), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    beat_t e;
    repeat (3) @(negedge clock);
    check_eq("rst_arready", 32'(arready_m), 32'd1);
    check_eq("rst_rvalid", 32'(rvalid_m), 32'd0);
    check_eq("rst_rlast", 32'(rlast_m), 32'd0);
    check_eq("rst_rresp", 32'(rresp_m), 32'd0);
    check_eq("rst_rid", 32'(rid_m), 32'd0);
    check_eq("rst_rdata", rdata_m, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      init_we = 1'b1; init_addr = 12'(i); init_data = 32'h100 + 32'(i);
      model_mem[i] = 32'h100 + 32'(i);
      @(negedge clock);
    end
    init_we = 1'b0;
    @(negedge clock);

    do_read("incr4",      1'b0, 32'h8000_0000, 4'd1, 8'd3, 3'd2, 2'd1, 0, 1);
    do_read("wrap4",      1'b0, 32'h8000_0008, 4'd2, 8'd3, 3'd2, 2'd2, 0, 1);
    do_read("incr_end",   1'b0, BASE + 32'(4 * DEPTH) - 32'd8, 4'd3, 8'd3, 3'd2, 2'd1, 0, 1);
    do_read("incr_stall", 1'b1, 32'h8000_0020, 4'd5, 8'd7, 3'd2, 2'd1, 1, 3);
    do_read("wrap8_lat3", 1'b1, 32'h8000_0014, 4'd6, 8'd7, 3'd2, 2'd2, 0, 3);
    do_read("size_err",   1'b0, 32'h8000_0000, 4'd7, 8'd1, 3'd1, 2'd1, 0, 1);
    do_read("burst3_err", 1'b0, 32'h8000_0000, 4'd8, 8'd0, 3'd2, 2'd3, 0, 1);
    do_read("wraplen_err",1'b0, 32'h8000_0000, 4'd9, 8'd2, 3'd2, 2'd2, 0, 1);
    do_read("wrapalign",  1'b0, 32'h8000_0002, 4'd10, 8'd1, 3'd2, 2'd2, 0, 1);
    do_read("below_base", 1'b0, 32'h7FFF_FFF8, 4'd11, 8'd1, 3'd2, 2'd1, 0, 1);
    do_read("fixed3",     1'b0, 32'h8000_0012, 4'd12, 8'd2, 3'd2, 2'd0, 1, 1);
    do_read("incr256",    1'b0, 32'h8000_0100, 4'd13, 8'd255, 3'd2, 2'd1, 0, 1);

    // Reset while the second beat of a len=7 burst is presented.
    sel = 1'b0; araddr = 32'h8000_0040; arid = 4'd4; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    e = model_beat(32'h8000_0040, 8'd7, 3'd2, 2'd1, 0);
    check_eq("abort_beat0", rdata_m, e.data);
    @(negedge clock);
    e = model_beat(32'h8000_0040, 8'd7, 3'd2, 2'd1, 1);
    check_eq("abort_beat1_valid", 32'(rvalid_m), 32'd1);
    check_eq("abort_beat1", rdata_m, e.data);
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort_rvalid", 32'(rvalid_m), 32'd0);
    check_eq("abort_arready", 32'(arready_m), 32'd1);
    check_eq("abort_rlast", 32'(rlast_m), 32'd0);
    reset = 1'b0; rready = 1'b0;
    @(negedge clock);
    do_read("after_reset", 1'b0, 32'h8000_0010, 4'd14, 8'd1, 3'd2, 2'd1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
